// File: rtl/pipe_control_pkg.sv
// Shared definitions for the pipeline controller: control-word layout,
// FSM encoding and the opcodes the controller cares about.
package pipe_control_pkg;
  localparam int CW = 16;
  typedef logic [CW-1:0] ctrl_t;

  localparam int B_SAVEPC   = 15;
  localparam int B_MEMTOREG = 14;
  localparam int B_MEMREAD  = 13;
  localparam int B_MEMWRITE = 12;
  localparam int B_ALUSRCB  = 11;
  localparam int B_SETDZ    = 10;
  localparam int B_SLD8     = 9;
  localparam int B_OFFSEL   = 8;
  localparam int B_CMP      = 7;
  localparam int B_REV      = 6;
  localparam int B_SEXT_LO  = 3;
  localparam int B_WRS_LO   = 1;
  localparam int B_RWE      = 0;

  localparam logic [2:0] SEXT_I = 3'b001;
  localparam logic [2:0] SEXT_B = 3'b010;
  localparam logic [1:0] WRS_RD = 2'b00;
  localparam logic [1:0] WRS_RT = 2'b01;
  localparam logic [1:0] WRS_RA = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  localparam logic [4:0] OP_HALT = 5'h00;
  localparam logic [4:0] OP_NOP  = 5'h01;
  localparam logic [4:0] OP_LD   = 5'h02;
  localparam logic [4:0] OP_ST   = 5'h03;
  localparam logic [4:0] OP_ADD  = 5'h04;
  localparam logic [4:0] OP_ADDI = 5'h05;
  localparam logic [4:0] OP_BEQ  = 5'h06;
  localparam logic [4:0] OP_JAL  = 5'h07;
endpackage

// File: rtl/pipe_control_if.sv
// Decode-side handshake and per-stage control outputs of pipe_control.
interface pipe_control_if import pipe_control_pkg::*; #(
  parameter int OPW = 5,
  parameter int AW  = 3
);
  logic           id_valid;
  logic [OPW-1:0] id_opcode;
  logic [AW-1:0]  id_rs;
  logic [AW-1:0]  id_rt;
  logic           id_uses_rs;
  logic           id_uses_rt;
  logic [AW-1:0]  id_rd;
  logic           flush;
  logic           id_ready;
  ctrl_t          ex_ctrl;
  ctrl_t          mem_ctrl;
  ctrl_t          wb_ctrl;
  logic           ex_valid;
  logic           mem_valid;
  logic           wb_valid;
  logic           halted;
  logic [15:0]    stall_cycles;

  modport master (
    output id_valid, id_opcode, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd, flush,
    input  id_ready, ex_ctrl, mem_ctrl, wb_ctrl, ex_valid, mem_valid, wb_valid,
           halted, stall_cycles
  );
  modport slave (
    input  id_valid, id_opcode, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd, flush,
    output id_ready, ex_ctrl, mem_ctrl, wb_ctrl, ex_valid, mem_valid, wb_valid,
           halted, stall_cycles
  );
endinterface

// File: rtl/pipe_control_ctrl_decode.sv
// Combinational opcode -> control-word table. Unknown opcodes, HALT and NOP
// decode to an all-zero word.
module ctrl_decode import pipe_control_pkg::*; #(
  parameter int OPW = 5
) (
  input  logic [OPW-1:0] opcode,
  output ctrl_t          ctrl
);
  always_comb begin
    ctrl = '0;
    case (opcode)
      OPW'(OP_LD): begin
        ctrl[B_MEMTOREG]         = 1'b1;
        ctrl[B_MEMREAD]          = 1'b1;
        ctrl[B_ALUSRCB]          = 1'b1;
        ctrl[B_SEXT_LO +: 3]     = SEXT_I;
        ctrl[B_WRS_LO +: 2]      = WRS_RT;
        ctrl[B_RWE]              = 1'b1;
      end
      OPW'(OP_ST): begin
        ctrl[B_MEMWRITE]         = 1'b1;
        ctrl[B_ALUSRCB]          = 1'b1;
        ctrl[B_SEXT_LO +: 3]     = SEXT_I;
      end
      OPW'(OP_ADD): begin
        ctrl[B_WRS_LO +: 2]      = WRS_RD;
        ctrl[B_RWE]              = 1'b1;
      end
      OPW'(OP_ADDI): begin
        ctrl[B_ALUSRCB]          = 1'b1;
        ctrl[B_SEXT_LO +: 3]     = SEXT_I;
        ctrl[B_WRS_LO +: 2]      = WRS_RT;
        ctrl[B_RWE]              = 1'b1;
      end
      OPW'(OP_BEQ): begin
        ctrl[B_OFFSEL]           = 1'b1;
        ctrl[B_CMP]              = 1'b1;
        ctrl[B_SEXT_LO +: 3]     = SEXT_B;
      end
      OPW'(OP_JAL): begin
        ctrl[B_SAVEPC]           = 1'b1;
        ctrl[B_WRS_LO +: 2]      = WRS_RA;
        ctrl[B_RWE]              = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end
endmodule

// File: rtl/pipe_control.sv
// EX/MEM/WB control pipeline with RAW hazard stall, flush kill and a
// RUN/DRAIN/HALTED halt sequencer. Stage index 0=EX, 1=MEM, 2=WB.
module pipe_control import pipe_control_pkg::*; #(
  parameter int             OPW     = 5,
  parameter int             AW      = 3,
  parameter int             FWD     = 1,
  parameter logic [OPW-1:0] HALT_OP = '0
) (
  input  logic         clk,
  input  logic         rst,
  pipe_control_if.slave bus
);
  localparam int STAGES = 3;

  logic [STAGES-1:0]       vld_q, vld_d;
  ctrl_t [STAGES-1:0]      ctrl_q, ctrl_d;
  logic [STAGES-1:0]       halt_q, halt_d;
  logic [1:0][AW-1:0]      rd_q, rd_d;
  state_e                  state_q, state_d;
  logic                    halted_q, halted_d;
  logic [15:0]             stall_q, stall_d;

  ctrl_t                   id_ctrl, id_word;
  logic [AW-1:0]           id_rd_word;
  logic [1:0]              hit;
  logic                    hz_raw, hazard, run, id_ready, accept, is_halt, stall_inc;

  ctrl_decode #(.OPW(OPW)) u_dec (.opcode(bus.id_opcode), .ctrl(id_ctrl));

  // Source match against writers still in EX/MEM; WB writes before ID reads.
  always_comb begin
    hit = '0;
    for (int s = 0; s < 2; s++)
      hit[s] = vld_q[s] & ctrl_q[s][B_RWE] &
               ((bus.id_uses_rs & (bus.id_rs == rd_q[s])) |
                (bus.id_uses_rt & (bus.id_rt == rd_q[s])));
  end

  assign hz_raw    = (FWD != 0) ? (hit[0] & ctrl_q[0][B_MEMREAD]) : (|hit);
  assign hazard    = bus.id_valid & hz_raw;
  assign run       = (state_q == ST_RUN);
  assign id_ready  = run & ~hazard & ~bus.flush;
  assign accept    = bus.id_valid & id_ready;
  assign is_halt   = (bus.id_opcode == HALT_OP);
  assign stall_inc = hazard & ~bus.flush & run;
  assign id_word    = accept ? id_ctrl : '0;
  assign id_rd_word = accept ? bus.id_rd : '0;

  always_comb begin
    vld_d   = {vld_q[1:0], accept};
    ctrl_d  = {ctrl_q[1:0], id_word};
    halt_d  = {halt_q[1:0], accept & is_halt};
    rd_d    = {rd_q[0], id_rd_word};
    stall_d = stall_q;
    if (stall_inc && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (accept && is_halt) state_d = ST_DRAIN;
      ST_DRAIN:  if (vld_q[2] && halt_q[2]) state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
    halted_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= '0;
      ctrl_q   <= '0;
      halt_q   <= '0;
      rd_q     <= '0;
      state_q  <= ST_RUN;
      halted_q <= 1'b0;
      stall_q  <= '0;
    end else begin
      vld_q    <= vld_d;
      ctrl_q   <= ctrl_d;
      halt_q   <= halt_d;
      rd_q     <= rd_d;
      state_q  <= state_d;
      halted_q <= halted_d;
      stall_q  <= stall_d;
    end
  end

  assign bus.id_ready     = id_ready;
  assign bus.ex_valid     = vld_q[0];
  assign bus.mem_valid    = vld_q[1];
  assign bus.wb_valid     = vld_q[2];
  assign bus.ex_ctrl      = ctrl_q[0];
  assign bus.mem_ctrl     = ctrl_q[1];
  assign bus.wb_ctrl      = ctrl_q[2];
  assign bus.halted       = halted_q;
  assign bus.stall_cycles = stall_q;
endmodule

// File: tb/tb_pipe_control.sv
// Directed bench: dut_a built with forwarding, dut_b without; expected control
// words are hand-encoded from the control-word bit layout.
module tb_pipe_control;
  localparam logic [4:0] HALT = 5'h00, NOP = 5'h01, LD = 5'h02, ST = 5'h03, ADD = 5'h04;
  localparam logic [31:0] W_LD = 32'h680B, W_ST = 32'h1808, W_ADD = 32'h0001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pipe_control_if #(.OPW(5), .AW(3)) ifa ();
  pipe_control_if #(.OPW(5), .AW(3)) ifb ();

  pipe_control #(.OPW(5), .AW(3), .FWD(1), .HALT_OP(5'b00000)) u_dut_a (.clk(clk), .rst(rst), .bus(ifa));
  pipe_control #(.OPW(5), .AW(3), .FWD(0), .HALT_OP(5'b00000)) u_dut_b (.clk(clk), .rst(rst), .bus(ifb));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic v, input logic [4:0] op, input logic [2:0] rs, input logic [2:0] rt,
                       input logic urs, input logic urt, input logic [2:0] rd, input logic fl);
    ifa.id_valid = v; ifa.id_opcode = op; ifa.id_rs = rs; ifa.id_rt = rt;
    ifa.id_uses_rs = urs; ifa.id_uses_rt = urt; ifa.id_rd = rd; ifa.flush = fl;
    #1;
  endtask

  task automatic drv_b(input logic v, input logic [4:0] op, input logic [2:0] rs, input logic [2:0] rt,
                       input logic urs, input logic urt, input logic [2:0] rd, input logic fl);
    ifb.id_valid = v; ifb.id_opcode = op; ifb.id_rs = rs; ifb.id_rt = rt;
    ifb.id_uses_rs = urs; ifb.id_uses_rt = urt; ifb.id_rd = rd; ifb.flush = fl;
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drv_a(0, NOP, 0, 0, 0, 0, 0, 0);
    drv_b(0, NOP, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("rst_a_vld",   {ifa.ex_valid, ifa.mem_valid, ifa.wb_valid}, 0);
    chk("rst_a_ctrl",  {ifa.ex_ctrl, ifa.wb_ctrl}, 0);
    chk("rst_a_state", {ifa.halted, ifa.stall_cycles}, 0);
    chk("rst_b_vld",   {ifb.ex_valid, ifb.mem_valid, ifb.wb_valid}, 0);
    rst = 1'b0;
    #1;
    chk("rst_a_rdy", ifa.id_ready, 1);
    chk("rst_b_rdy", ifb.id_ready, 1);

    // load-use with forwarding: one bubble
    drv_a(1, LD, 2, 0, 1, 0, 1, 0);
    chk("lu_ld_rdy", ifa.id_ready, 1);
    tick();
    drv_a(1, ADD, 1, 3, 1, 1, 4, 0);
    chk("lu_ex_ld_vld", ifa.ex_valid, 1);
    chk("lu_ex_ld_ctrl", ifa.ex_ctrl, W_LD);
    chk("lu_stall_rdy", ifa.id_ready, 0);
    tick();
    chk("lu_bubble_vld", ifa.ex_valid, 0);
    chk("lu_bubble_ctrl", ifa.ex_ctrl, 0);
    chk("lu_mem_ctrl", ifa.mem_ctrl, W_LD);
    chk("lu_stall_cnt", ifa.stall_cycles, 1);
    chk("lu_retry_rdy", ifa.id_ready, 1);
    tick();
    drv_a(0, NOP, 0, 0, 0, 0, 0, 0);
    chk("lu_ex_add", {ifa.ex_valid, ifa.ex_ctrl}, {1'b1, W_ADD[15:0]});
    chk("lu_mem_bubble", ifa.mem_valid, 0);
    chk("lu_wb_ld", {ifa.wb_valid, ifa.wb_ctrl}, {1'b1, W_LD[15:0]});
    tick();
    chk("lu_stall_hold", ifa.stall_cycles, 1);

    // no forwarding: ALU RAW stalls for EX and MEM, not WB
    drv_b(1, ADD, 5, 6, 1, 1, 2, 0);
    chk("nf_w_rdy", ifb.id_ready, 1);
    tick();
    drv_b(1, ADD, 0, 2, 0, 1, 7, 0);
    chk("nf_raw_ex_rdy", ifb.id_ready, 0);
    tick();
    chk("nf_raw_mem_rdy", ifb.id_ready, 0);
    chk("nf_bubble", {ifb.ex_valid, ifb.mem_valid}, 2'b01);
    tick();
    chk("nf_wb_rdy", ifb.id_ready, 1);
    chk("nf_stall_cnt", ifb.stall_cycles, 2);
    tick();
    drv_b(1, ADD, 7, 7, 0, 0, 3, 0);
    chk("nf_ex_add", {ifb.ex_valid, ifb.ex_ctrl}, {1'b1, W_ADD[15:0]});
    chk("nf_unused_src_rdy", ifb.id_ready, 1);
    tick();
    drv_b(0, NOP, 0, 0, 0, 0, 0, 0);
    chk("nf_stall_hold", ifb.stall_cycles, 2);

    // same ALU RAW with forwarding: no stall
    drv_a(1, ADD, 5, 6, 1, 1, 2, 0);
    tick();
    drv_a(1, ADD, 0, 2, 0, 1, 7, 0);
    chk("fw_raw_rdy", ifa.id_ready, 1);
    tick();
    drv_a(0, NOP, 0, 0, 0, 0, 0, 0);
    chk("fw_ex_add", {ifa.ex_valid, ifa.ex_ctrl}, {1'b1, W_ADD[15:0]});
    chk("fw_stall_cnt", ifa.stall_cycles, 1);

    // flush kills the ID instruction; flush beats hazard in the stall count
    drv_a(1, ST, 1, 2, 1, 1, 0, 0);
    chk("fl_st_rdy", ifa.id_ready, 1);
    tick();
    drv_a(1, ADD, 3, 3, 1, 1, 3, 1);
    chk("fl_ex_st", ifa.ex_ctrl, W_ST);
    chk("fl_rdy", ifa.id_ready, 0);
    tick();
    drv_a(1, LD, 2, 0, 1, 0, 1, 0);
    chk("fl_killed", ifa.ex_valid, 0);
    tick();
    drv_a(1, ADD, 1, 1, 1, 1, 4, 1);
    chk("fl_hz_rdy", ifa.id_ready, 0);
    tick();
    drv_a(0, NOP, 0, 0, 0, 0, 0, 0);
    chk("fl_hz_nocount", ifa.stall_cycles, 1);
    chk("fl_hz_killed", ifa.ex_valid, 0);

    // halt killed by flush leaves state in RUN
    drv_b(1, HALT, 0, 0, 0, 0, 0, 1);
    chk("hk_rdy", ifb.id_ready, 0);
    tick();
    drv_b(0, NOP, 0, 0, 0, 0, 0, 0);
    chk("hk_ex", ifb.ex_valid, 0);
    chk("hk_run_rdy", ifb.id_ready, 1);

    // halt drain
    drv_a(1, HALT, 0, 0, 0, 0, 0, 0);
    chk("h_rdy", ifa.id_ready, 1);
    tick();
    drv_a(1, ADD, 1, 2, 1, 1, 3, 0);
    chk("h_drain_rdy", ifa.id_ready, 0);
    chk("h_ex", {ifa.ex_valid, ifa.ex_ctrl}, {1'b1, 16'h0000});
    chk("h_c1_halted", ifa.halted, 0);
    tick();
    chk("h_c2", {ifa.ex_valid, ifa.mem_valid}, 2'b01);
    tick();
    chk("h_c3", {ifa.wb_valid, ifa.halted}, 2'b10);
    tick();
    chk("h_halted", {ifa.halted, ifa.id_ready}, 2'b10);
    repeat (3) tick();
    chk("h_hold", {ifa.halted, ifa.ex_valid, ifa.mem_valid, ifa.wb_valid}, 4'b1000);
    drv_a(0, NOP, 0, 0, 0, 0, 0, 0);

    // reset in DRAIN (and while dut_a is halted)
    drv_b(1, HALT, 0, 0, 0, 0, 0, 0);
    tick();
    drv_b(0, NOP, 0, 0, 0, 0, 0, 0);
    chk("rd_drain", {ifb.id_ready, ifb.ex_valid}, 2'b01);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rd_b_vld", {ifb.ex_valid, ifb.mem_valid, ifb.wb_valid}, 0);
    chk("rd_b_state", {ifb.halted, ifb.id_ready, ifb.stall_cycles}, {2'b01, 16'h0000});
    chk("rd_a_state", {ifa.halted, ifa.id_ready, ifa.stall_cycles}, {2'b01, 16'h0000});

    // saturation: 65537 forced stall cycles
    force u_dut_a.hazard = 1'b1;
    drv_a(1, ADD, 1, 1, 1, 1, 2, 0);
    chk("sat_rdy", ifa.id_ready, 0);
    repeat (65534) tick();
    chk("sat_fffe", ifa.stall_cycles, 32'hFFFE);
    tick();
    chk("sat_ffff", ifa.stall_cycles, 32'hFFFF);
    repeat (2) tick();
    chk("sat_hold", ifa.stall_cycles, 32'hFFFF);
    release u_dut_a.hazard;
    drv_a(0, NOP, 0, 0, 0, 0, 0, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
